hazard_fwd_unit: RTL

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - pipeline forwarding, load-use stall and branch flush control
// Optional macro HAZARD_PERF_CNT_EN enables saturating stall/flush/forward counters.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use1,
  input  logic                  id_use2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwr,
  input  logic                  ex_memrd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwr,
  input  logic                  mem_memrd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwr,
  input  logic                  br_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  rf_byp1,
  output logic                  rf_byp2,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic [CNT_W-1:0]      perf_stall,
  output logic [CNT_W-1:0]      perf_flush,
  output logic [CNT_W-1:0]      perf_fwd
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state, state_nxt;
  logic [2:0] stall_cnt, stall_cnt_nxt;
  logic       haz;
  logic       stall;
  logic       mem_fwd_ok;
  logic       wb_fwd_ok;

  // Loads in MEM have no data yet, so they never feed the EX/MEM path.
  assign mem_fwd_ok = mem_regwr && !mem_memrd && (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwr && (wb_rd != '0);

  always_comb begin
    fwd_a_sel = 2'b00;
    if (mem_fwd_ok && (mem_rd == ex_rs1))
      fwd_a_sel = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rs1))
      fwd_a_sel = 2'b01;
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if (mem_fwd_ok && (mem_rd == ex_rs2))
      fwd_b_sel = 2'b10;
    else if (wb_fwd_ok && (wb_rd == ex_rs2))
      fwd_b_sel = 2'b01;
  end

  assign rf_byp1 = wb_fwd_ok && (wb_rd == id_rs1);
  assign rf_byp2 = wb_fwd_ok && (wb_rd == id_rs2);

  assign haz = ex_memrd && ex_regwr && (ex_rd != '0) &&
               ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

  // While rst is high the outputs are evaluated as if the FSM were in IDLE.
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    stall         = 1'b0;
    ifid_flush    = 1'b0;
    if (br_taken) begin
      ifid_flush    = 1'b1;
      state_nxt     = IDLE;
      stall_cnt_nxt = 3'd0;
    end else if (rst || (state == IDLE)) begin
      if (haz) begin
        stall = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt     = STALL;
          stall_cnt_nxt = 3'(LOAD_LAT - 1);
        end
      end
    end else begin
      stall         = 1'b1;
      stall_cnt_nxt = stall_cnt - 3'd1;
      if (stall_cnt <= 3'd1) begin
        state_nxt     = IDLE;
        stall_cnt_nxt = 3'd0;
      end
    end
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall || br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stall_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic fwd_any;
  assign fwd_any = (fwd_a_sel != 2'b00) || (fwd_b_sel != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_fwd   <= '0;
    end else begin
      if (stall && !(&perf_stall))
        perf_stall <= perf_stall + CNT_W'(1);
      if (br_taken && !(&perf_flush))
        perf_flush <= perf_flush + CNT_W'(1);
      if (fwd_any && !(&perf_fwd))
        perf_fwd <= perf_fwd + CNT_W'(1);
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_fwd   = '0;
`endif

endmodule
